// File: rtl/row_input_ctrl_pkg.sv
// Shared array geometry and operand types for the systolic row input path.
// Optional feature macro used by this slice: ROW_IN_SKEW_EN.
package systola_pkg;

   localparam int LANES = 8;
   localparam int DW    = 8;
   localparam int BUSW  = 32;
   localparam int WPV   = LANES * DW / BUSW;

   typedef logic [DW-1:0] lane_t;
   typedef lane_t [LANES-1:0] vec_t;

   // A counter over n values still needs one bit when n is 1.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/row_input_ctrl_if.sv
// Host word handshake plus array-side operand outputs of the row input controller.
// Host side: a word moves on a rising edge where wvalid && wready; in_w is held stable while wvalid waits.
interface row_input_ctrl_if;
   import systola_pkg::*;

   logic [BUSW-1:0]  in_w;
   logic             wvalid;
   logic             wready;
   logic             arr_rdy;
   vec_t             out_r;
   logic [LANES-1:0] out_v;

   modport master (output in_w, wvalid, arr_rdy, input wready, out_r, out_v);
   modport slave  (input in_w, wvalid, arr_rdy, output wready, out_r, out_v);
endinterface

// File: rtl/row_input_ctrl_skew.sv
// Enable-gated delay line for one lane's operand and valid; DEPTH=0 is a plain wire.
module lane_skew_delay
   import systola_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  lane_t d,
   input  logic  dv,
   output lane_t q,
   output logic  qv
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ctl;
         assign unused_ctl = ^{clk, rst, en};
         assign q  = d;
         assign qv = dv;
      end else begin : g_dly
         lane_t            r [DEPTH];
         logic [DEPTH-1:0] v;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int k = 0; k < DEPTH; k++) r[k] <= '0;
               v <= '0;
            end else if (en) begin
               r[0] <= d;
               v[0] <= dv;
               for (int k = 1; k < DEPTH; k++) begin
                  r[k] <= r[k-1];
                  v[k] <= v[k-1];
               end
            end
         end

         assign q  = r[DEPTH-1];
         assign qv = v[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/row_input_ctrl.sv
// Packs host words into LANES x DW vectors and issues them to the array rows.
// ROW_IN_SKEW_EN defined: lane i lags lane 0 by i cycles; undefined: all lanes issue together.
module row_input_ctrl
   import systola_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   row_input_ctrl_if.slave  bus
);

   localparam int             CW   = cnt_width(WPV);
   localparam logic [CW-1:0]  LAST = CW'(WPV - 1);

   logic [CW-1:0]        wcnt;
   logic [LANES*DW-1:0]  asm_q;
   logic [LANES*DW-1:0]  full_vec;
   vec_t                 pend_q;
   logic                 pend_full;
   vec_t                 stage0;
   logic                 stage0_v;
   logic                 xfer;
   logic                 last_word;

   lane_t                lane_r [LANES];
   logic [LANES-1:0]     lane_v;
   vec_t                 out_pack;

   // A full pend slot can still take the closing word when the array drains it on the same edge.
   assign bus.wready = !rst && (!pend_full || bus.arr_rdy);
   assign xfer       = bus.wvalid && bus.wready;
   assign last_word  = (wcnt == LAST);

   always_comb begin
      full_vec = asm_q;
      full_vec[(WPV-1)*BUSW +: BUSW] = bus.in_w;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wcnt      <= '0;
         asm_q     <= '0;
         pend_q    <= '0;
         pend_full <= 1'b0;
      end else begin
         if (xfer) begin
            wcnt <= last_word ? '0 : wcnt + 1'b1;
            if (!last_word) asm_q[int'(wcnt)*BUSW +: BUSW] <= bus.in_w;
         end
         if (xfer && last_word) begin
            pend_q    <= full_vec;
            pend_full <= 1'b1;
         end else if (bus.arr_rdy && pend_full) begin
            pend_full <= 1'b0;
         end
      end
   end

   // Bubbles carry zero data so idle lanes present a clean operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage0   <= '0;
         stage0_v <= 1'b0;
      end else if (bus.arr_rdy) begin
         stage0   <= pend_full ? pend_q : '0;
         stage0_v <= pend_full;
      end
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef ROW_IN_SKEW_EN
         lane_skew_delay #(.DEPTH(i)) u_dly (
            .clk (clk),
            .rst (rst),
            .en  (bus.arr_rdy),
            .d   (stage0[i]),
            .dv  (stage0_v),
            .q   (lane_r[i]),
            .qv  (lane_v[i])
         );
`else
         assign lane_r[i] = stage0[i];
         assign lane_v[i] = stage0_v;
`endif
      end
   endgenerate

   always_comb begin
      out_pack = '0;
      for (int i = 0; i < LANES; i++) out_pack[i] = lane_r[i];
   end

   assign bus.out_r = out_pack;
   assign bus.out_v = lane_v;

endmodule

// File: tb/tb_row_input_ctrl.sv
// Directed bench for row_input_ctrl: cycle tables for reset/single vector, scoreboard for stall, stream and reset recovery.
module tb_row_input_ctrl;
   import systola_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   row_input_ctrl_if bus();

   row_input_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;
   bit sb_en  = 1'b0;
   logic [DW-1:0] exp_q [LANES][$];

   typedef struct {
      logic [BUSW-1:0]  w;
      logic             wv;
      logic             rdy;
      logic             exp_wready;
      logic [LANES-1:0] exp_v;
      logic [63:0]      exp_r;
   } vec_rec_t;

   vec_rec_t tbl [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [BUSW-1:0] w, input logic wv, input logic rdy);
      bus.in_w    = w;
      bus.wvalid  = wv;
      bus.arr_rdy = rdy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drain_and_check(input string tag);
      drive('0, 1'b0, 1'b1);
      repeat (20) next_cycle();
      for (int i = 0; i < LANES; i++)
         check($sformatf("%s_left_lane%0d", tag, i), 64'(exp_q[i].size()), 64'd0);
   endtask

   // Scoreboard: the array consumes a lane element on an edge where it is valid and arr_rdy is high.
   always @(negedge clk) begin
      if (sb_en && !rst) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.out_v[i] && bus.arr_rdy) begin
               if (exp_q[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_extra_lane%0d: got %h expected none", i, bus.out_r[i]);
               end else begin
                  check($sformatf("sb_lane%0d", i), 64'(bus.out_r[i]), 64'(exp_q[i].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      logic [BUSW-1:0] word;

      for (int r = 0; r < 12; r++) begin
         tbl[r].w = '0;  tbl[r].wv = 1'b0;  tbl[r].rdy = 1'b1;
         tbl[r].exp_wready = 1'b1;  tbl[r].exp_v = '0;  tbl[r].exp_r = '0;
      end
      tbl[0].w = 32'h04030201;  tbl[0].wv = 1'b1;
      tbl[1].w = 32'h08070605;  tbl[1].wv = 1'b1;
`ifdef ROW_IN_SKEW_EN
      for (int i = 0; i < LANES; i++) begin
         tbl[3+i].exp_v = LANES'(1 << i);
         tbl[3+i].exp_r = 64'(i + 1) << (8 * i);
      end
`else
      tbl[3].exp_v = 8'hFF;
      tbl[3].exp_r = 64'h0807060504030201;
`endif

      // Reset held with wvalid high.
      drive(32'hA5A5A5A5, 1'b1, 1'b1);
      repeat (3) begin
         @(negedge clk);
         check("rst_wready", 64'(bus.wready), 64'd0);
         check("rst_out_v", 64'(bus.out_v), 64'd0);
         check("rst_out_r", 64'(bus.out_r), 64'd0);
      end
      next_cycle();
      rst = 1'b0;

      // Single vector, cycle by cycle.
      for (int r = 0; r < 12; r++) begin
         drive(tbl[r].w, tbl[r].wv, tbl[r].rdy);
         @(negedge clk);
         check($sformatf("vec_wready_r%0d", r), 64'(bus.wready), 64'(tbl[r].exp_wready));
         check($sformatf("vec_out_v_r%0d", r), 64'(bus.out_v), 64'(tbl[r].exp_v));
         check($sformatf("vec_out_r_r%0d", r), 64'(bus.out_r), tbl[r].exp_r);
         next_cycle();
      end

      // Stall right after the issue edge while the next vector fills pend.
      sb_en = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         exp_q[i].push_back(DW'(i + 1));
         exp_q[i].push_back(DW'(8'h11 + i));
      end
      drive(32'h04030201, 1'b1, 1'b1);  next_cycle();
      drive(32'h08070605, 1'b1, 1'b1);  next_cycle();
      drive('0, 1'b0, 1'b1);            next_cycle();
      for (int c = 0; c < 4; c++) begin
         case (c)
            0: drive(32'h14131211, 1'b1, 1'b0);
            1: drive(32'h18171615, 1'b1, 1'b0);
            default: drive(32'hDEADBEEF, 1'b1, 1'b0);
         endcase
         @(negedge clk);
         check($sformatf("stall_wready_c%0d", c), 64'(bus.wready), (c < 2) ? 64'd1 : 64'd0);
`ifdef ROW_IN_SKEW_EN
         check($sformatf("stall_out_v_c%0d", c), 64'(bus.out_v), 64'h01);
         check($sformatf("stall_out_r_c%0d", c), 64'(bus.out_r), 64'h01);
`else
         check($sformatf("stall_out_v_c%0d", c), 64'(bus.out_v), 64'hFF);
         check($sformatf("stall_out_r_c%0d", c), 64'(bus.out_r), 64'h0807060504030201);
`endif
         next_cycle();
      end
      drain_and_check("stall");

      // Six vectors streamed back to back.
      for (int n = 0; n < 6; n++)
         for (int i = 0; i < LANES; i++) exp_q[i].push_back(DW'(8'h30 + n * 8 + i));
      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k < WPV; k++) begin
            for (int j = 0; j < BUSW / DW; j++) word[8*j +: 8] = 8'(8'h30 + n * 8 + k * 4 + j);
            drive(word, 1'b1, 1'b1);
            @(negedge clk);
            check($sformatf("stream_wready_v%0d_w%0d", n, k), 64'(bus.wready), 64'd1);
            next_cycle();
         end
      end
      drain_and_check("stream");

      // Reset after a lone first word; the partial vector must vanish.
      drive(32'h99999999, 1'b1, 1'b1);  next_cycle();
      rst = 1'b1;
      drive('0, 1'b0, 1'b1);
      @(negedge clk);
      check("midrst_wready", 64'(bus.wready), 64'd0);
      check("midrst_out_v", 64'(bus.out_v), 64'd0);
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < LANES; i++) exp_q[i].push_back(DW'(8'h21 + i));
      drive(32'h24232221, 1'b1, 1'b1);  next_cycle();
      drive(32'h28272625, 1'b1, 1'b1);  next_cycle();
      drain_and_check("midrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
